// File: rtl/serdes_pkg.sv
// Shared types and sizing helpers for the serial deserializer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serdes_pkg;

    // Width of a bit counter that indexes 0..width-1 inside one word.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    // Occupancy of the single-entry output buffer.
    typedef enum logic [0:0] {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage : serdes_pkg

// File: rtl/sipo_shift_stage.sv
// Serial-in/parallel-out shift stage: assembles WIDTH serial bits into a word.
// Latency: word_o/done_o are combinational on the completing bit (same cycle).
// Backpressure: none; the stage always accepts a bit, the consumer decides to keep or drop it.
module sipo_shift_stage
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sync_i,
    input  logic             sin_valid_i,
    input  logic             sin_data_i,
    output logic [WIDTH-1:0] word_o,
    output logic             done_o
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] shifted;

    // Shift the incoming bit in; a sync restarts from an empty word so the bit becomes bit 0.
    always_comb begin
        base = sync_i ? '0 : shreg_q;
        if (LSB_FIRST) begin
            shifted = {sin_data_i, base[WIDTH-1:1]};
        end else begin
            shifted = {base[WIDTH-2:0], sin_data_i};
        end
    end

    // Next-state for the partial word and bit counter; sync beats completion.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_o  = 1'b0;
        if (sync_i) begin
            shreg_d = sin_valid_i ? shifted : '0;
            cnt_d   = sin_valid_i ? CW'(1) : '0;
        end else if (sin_valid_i) begin
            if (cnt_q == LAST_CNT) begin
                shreg_d = '0;
                cnt_d   = '0;
                done_o  = 1'b1;
            end else begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // The completed word is the stored bits plus the bit arriving now.
    assign word_o = shifted;

    // Partial-word state; reset discards any half-received word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : sipo_shift_stage

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver with a one-word output buffer and valid/ready handshake.
// Latency: dout_valid rises one cycle after the last bit of a word.
// Backpressure: a word completing while the buffer is full and not drained is dropped; overrun pulses.
module serial_deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sync,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    logic [WIDTH-1:0] word;
    logic             done;

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overrun_q, overrun_d;

    sipo_shift_stage #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clock       (clock),
        .reset       (reset),
        .sync_i      (sync),
        .sin_valid_i (sin_valid),
        .sin_data_i  (sin_data),
        .word_o      (word),
        .done_o      (done)
    );

    // Output buffer FSM: a drain and a completion in the same cycle swap words without a bubble.
    always_comb begin
        state_d   = state_q;
        dout_d    = dout_q;
        overrun_d = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (done) begin
                    dout_d  = word;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (done && dout_ready) begin
                    dout_d = word;
                end else if (done) begin
                    overrun_d = 1'b1;
                end else if (dout_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
            end
        endcase
    end

    // Buffer registers; reset clears them asynchronously so dout_valid drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= BUF_EMPTY;
            dout_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == BUF_FULL);
    assign overrun    = overrun_q;

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Directed bench: two instances (LSB-first and MSB-first) share one stimulus stream.
// Expectations come from a hand-computed per-cycle table plus short reset sequences.
// Outputs are sampled 1 time unit after the rising edge.
module tb_serial_deserializer;

    logic       clock;
    logic       reset;
    logic       sync;
    logic       sin_valid;
    logic       sin_data;
    logic       dout_ready;
    logic [3:0] dout_l, dout_m;
    logic       vld_l, vld_m;
    logic       ovr_l, ovr_m;

    int checks;
    int failures;

    serial_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
        .clock      (clock),
        .reset      (reset),
        .sync       (sync),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .dout       (dout_l),
        .dout_valid (vld_l),
        .dout_ready (dout_ready),
        .overrun    (ovr_l)
    );

    serial_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
        .clock      (clock),
        .reset      (reset),
        .sync       (sync),
        .sin_valid  (sin_valid),
        .sin_data   (sin_data),
        .dout       (dout_m),
        .dout_valid (vld_m),
        .dout_ready (dout_ready),
        .overrun    (ovr_m)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic       sy;
        logic       v;
        logic       d;
        logic       rdy;
        logic [3:0] el;
        logic       vl;
        logic       ol;
        logic [3:0] em;
        logic       vm;
        logic       om;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sy, input logic v, input logic d, input logic rdy,
                       input logic [3:0] el, input logic vl, input logic ol,
                       input logic [3:0] em, input logic vm, input logic om);
        vec_t r;
        r.sy = sy; r.v = v; r.d = d; r.rdy = rdy;
        r.el = el; r.vl = vl; r.ol = ol;
        r.em = em; r.vm = vm; r.om = om;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] el, input logic vl, input logic ol,
                           input logic [3:0] em, input logic vm, input logic om);
        chk("lsb_dout",    idx, dout_l,       el);
        chk("lsb_valid",   idx, {3'b0, vld_l}, {3'b0, vl});
        chk("lsb_overrun", idx, {3'b0, ovr_l}, {3'b0, ol});
        chk("msb_dout",    idx, dout_m,       em);
        chk("msb_valid",   idx, {3'b0, vld_m}, {3'b0, vm});
        chk("msb_overrun", idx, {3'b0, ovr_m}, {3'b0, om});
    endtask

    // Drive one cycle of inputs, let the edge happen, then leave the bench just after it.
    task automatic drive(input logic sy, input logic v, input logic d, input logic rdy);
        sync       = sy;
        sin_valid  = v;
        sin_data   = d;
        dout_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        sync       = 1'b0;
        sin_valid  = 1'b0;
        sin_data   = 1'b0;
        dout_ready = 1'b0;

        // Test 1 + 2: bits 1,0,1,1 -> LSB 1101, MSB 1011; then drain.
        add(0,1,1,0, 4'h0,0,0, 4'h0,0,0);
        add(0,1,0,0, 4'h0,0,0, 4'h0,0,0);
        add(0,1,1,0, 4'h0,0,0, 4'h0,0,0);
        add(0,1,1,0, 4'hD,1,0, 4'hB,1,0);
        add(0,0,0,1, 4'hD,0,0, 4'hB,0,0);
        // Test 3: word A then 5 without ready; second word dropped with overrun pulse.
        add(0,1,0,0, 4'hD,0,0, 4'hB,0,0);
        add(0,1,1,0, 4'hD,0,0, 4'hB,0,0);
        add(0,1,0,0, 4'hD,0,0, 4'hB,0,0);
        add(0,1,1,0, 4'hA,1,0, 4'h5,1,0);
        add(0,1,1,0, 4'hA,1,0, 4'h5,1,0);
        add(0,1,0,0, 4'hA,1,0, 4'h5,1,0);
        add(0,1,1,0, 4'hA,1,0, 4'h5,1,0);
        add(0,1,0,0, 4'hA,1,1, 4'h5,1,1);
        add(0,0,0,0, 4'hA,1,0, 4'h5,1,0);
        add(0,0,0,1, 4'hA,0,0, 4'h5,0,0);
        // Test 4: hold 3, then completion of C with ready in the same cycle.
        add(0,1,1,0, 4'hA,0,0, 4'h5,0,0);
        add(0,1,1,0, 4'hA,0,0, 4'h5,0,0);
        add(0,1,0,0, 4'hA,0,0, 4'h5,0,0);
        add(0,1,0,0, 4'h3,1,0, 4'hC,1,0);
        add(0,1,0,0, 4'h3,1,0, 4'hC,1,0);
        add(0,1,0,0, 4'h3,1,0, 4'hC,1,0);
        add(0,1,1,0, 4'h3,1,0, 4'hC,1,0);
        add(0,1,1,1, 4'hC,1,0, 4'h3,1,0);
        add(0,0,0,1, 4'hC,0,0, 4'h3,0,0);
        // Test 5: three bits lost to sync, then 0,1,1,0 with idle gaps.
        add(0,1,1,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,1,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,1,0, 4'hC,0,0, 4'h3,0,0);
        add(1,0,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,0,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,1,0, 4'hC,0,0, 4'h3,0,0);
        add(0,0,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,0,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,1,0, 4'hC,0,0, 4'h3,0,0);
        add(0,0,0,0, 4'hC,0,0, 4'h3,0,0);
        add(0,1,0,0, 4'h6,1,0, 4'h6,1,0);
        add(0,0,0,1, 4'h6,0,0, 4'h6,0,0);
        // Sync with a bit on the would-be completing cycle: no completion, bit starts a new word.
        add(0,1,1,0, 4'h6,0,0, 4'h6,0,0);
        add(0,1,1,0, 4'h6,0,0, 4'h6,0,0);
        add(0,1,1,0, 4'h6,0,0, 4'h6,0,0);
        add(1,1,1,0, 4'h6,0,0, 4'h6,0,0);
        add(0,1,0,0, 4'h6,0,0, 4'h6,0,0);
        add(0,1,0,0, 4'h6,0,0, 4'h6,0,0);
        add(0,1,0,0, 4'h1,1,0, 4'h8,1,0);
        add(0,0,0,1, 4'h1,0,0, 4'h8,0,0);

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk_all(-1, 4'h0, 0, 0, 4'h0, 0, 0);
        reset = 1'b0;

        // Mid-word reset after two bits; the table's first word must not include them.
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        #2 reset = 1'b1;
        #1 chk_all(-2, 4'h0, 0, 0, 4'h0, 0, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].sy, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk_all(i, tbl[i].el, tbl[i].vl, tbl[i].ol, tbl[i].em, tbl[i].vm, tbl[i].om);
        end

        // Test 6: reset while a word is held clears outputs before the next edge.
        drive(0, 1, 1, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk_all(-3, 4'h3, 1, 0, 4'hC, 1, 0);
        #2 reset = 1'b1;
        #1 chk_all(-4, 4'h0, 0, 0, 4'h0, 0, 0);
        drive(0, 0, 0, 0);
        chk_all(-5, 4'h0, 0, 0, 4'h0, 0, 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_deserializer
